// File: rtl/toy_pkg.sv
// Shared constants, serializer state type and ASCII helpers for the stdout hex printer.
package toy_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam int unsigned HEX_CHARS_PER_WORD = 4;

    // Four hex digits followed by CR and LF.
    localparam int unsigned CHARS_PER_WORD = HEX_CHARS_PER_WORD + 2;
    localparam logic [2:0] LAST_CHAR_IDX = 3'(CHARS_PER_WORD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Uppercase ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Character idx (0..5) of the printed form of word: four nibbles MSB first, CR, LF.
    function automatic logic [7:0] word_char(input logic [15:0] word, input logic [2:0] idx);
        case (idx)
            3'd0:    return hex_ascii(word[15:12]);
            3'd1:    return hex_ascii(word[11:8]);
            3'd2:    return hex_ascii(word[7:4]);
            3'd3:    return hex_ascii(word[3:0]);
            3'd4:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a val/rdy byte input; frames chain without gaps.
module uart_tx_byte
    import toy_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       val_i,
    input  logic [7:0] data_i,
    output logic       rdy_o,
    output logic       tx_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    tx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);
    // A byte is taken when idle, or on the last cycle of a stop bit so frames abut.
    assign rdy_o    = (state_q == StIdle) || ((state_q == StStop) && cnt_zero);
    assign tx_o     = tx_q;

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (val_i) begin
                        state_q <= StStart;
                        cnt_q   <= CntMax;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_zero) begin
                        state_q   <= StData;
                        cnt_q     <= CntMax;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_zero) begin
                        cnt_q <= CntMax;
                        if (bit_idx_q == 3'd7) begin
                            state_q   <= StStop;
                            bit_idx_q <= '0;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_zero) begin
                        if (val_i) begin
                            state_q <= StStart;
                            cnt_q   <= CntMax;
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/stdout_hex_tx.sv
// Prints each accepted 16-bit word as "HHHH\r\n" on a UART line, with a one-word holding buffer.
module stdout_hex_tx
    import toy_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        stdout_val_i,
    input  logic [15:0] stdout_data_i,
    output logic        stdout_rdy_o,
    output logic        tx_o,
    output logic        busy_o
);

    logic        rdy_en_q;
    logic        act_valid_q, act_valid_d;
    logic [15:0] act_word_q, act_word_d;
    logic [2:0]  char_idx_q, char_idx_d;
    logic        lf_busy_q, lf_busy_d;
    logic        hold_full_q, hold_full_d;
    logic [15:0] hold_word_q, hold_word_d;

    logic        char_val;
    logic        char_rdy;
    logic [7:0]  char_byte;
    logic        accept;
    logic        lf_done;

    assign stdout_rdy_o = rdy_en_q & ~hold_full_q;
    assign accept       = stdout_val_i & stdout_rdy_o;
    assign busy_o       = act_valid_q | hold_full_q;
    // While the LF is on the line the serializer is only ready at the end of its stop bit.
    assign lf_done      = lf_busy_q & char_rdy;

    // Next character: from the active word, or the held word's first digit once LF completes.
    always_comb begin
        char_val  = 1'b0;
        char_byte = ASCII_LF;
        if (act_valid_q && !lf_busy_q) begin
            char_val  = 1'b1;
            char_byte = word_char(act_word_q, char_idx_q);
        end else if (lf_busy_q && hold_full_q) begin
            char_val  = 1'b1;
            char_byte = word_char(hold_word_q, 3'd0);
        end
    end

    // Word sequencing: character index, LF completion, hand-off and acceptance.
    always_comb begin
        act_valid_d = act_valid_q;
        act_word_d  = act_word_q;
        char_idx_d  = char_idx_q;
        lf_busy_d   = lf_busy_q;
        hold_full_d = hold_full_q;
        hold_word_d = hold_word_q;

        if (lf_done) begin
            lf_busy_d = 1'b0;
            if (hold_full_q) begin
                // Held word's first digit is taken by the serializer on this same edge.
                act_valid_d = 1'b1;
                act_word_d  = hold_word_q;
                hold_full_d = 1'b0;
                char_idx_d  = 3'd1;
            end else begin
                act_valid_d = 1'b0;
            end
        end else if (char_val && char_rdy) begin
            if (char_idx_q == LAST_CHAR_IDX) begin
                lf_busy_d  = 1'b1;
                char_idx_d = '0;
            end else begin
                char_idx_d = char_idx_q + 3'd1;
            end
        end

        if (accept) begin
            if (!act_valid_d && !hold_full_d) begin
                act_valid_d = 1'b1;
                act_word_d  = stdout_data_i;
                char_idx_d  = '0;
            end else begin
                hold_full_d = 1'b1;
                hold_word_d = stdout_data_i;
            end
        end
    end

    // Sequencing state; ready is held off until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            act_valid_q <= 1'b0;
            act_word_q  <= '0;
            char_idx_q  <= '0;
            lf_busy_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_word_q <= '0;
        end else begin
            rdy_en_q    <= 1'b1;
            act_valid_q <= act_valid_d;
            act_word_q  <= act_word_d;
            char_idx_q  <= char_idx_d;
            lf_busy_q   <= lf_busy_d;
            hold_full_q <= hold_full_d;
            hold_word_q <= hold_word_d;
        end
    end

    uart_tx_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_uart_tx_byte (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .val_i (char_val),
        .data_i(char_byte),
        .rdy_o (char_rdy),
        .tx_o  (tx_o)
    );

endmodule

// File: tb/tb_stdout_hex_tx.sv
// Scoreboard bench: drivers push expected characters, UART decoders pop and compare.
module tb_stdout_hex_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        val  [3];
    logic [15:0] data [3];
    logic        rdy  [3];
    logic        tx   [3];
    logic        busy [3];

    stdout_hex_tx #(.CLK_DIV(4)) u_div4 (
        .clk_i(clk), .rst_n(rst_n), .stdout_val_i(val[0]), .stdout_data_i(data[0]),
        .stdout_rdy_o(rdy[0]), .tx_o(tx[0]), .busy_o(busy[0])
    );
    stdout_hex_tx #(.CLK_DIV(2)) u_div2 (
        .clk_i(clk), .rst_n(rst_n), .stdout_val_i(val[1]), .stdout_data_i(data[1]),
        .stdout_rdy_o(rdy[1]), .tx_o(tx[1]), .busy_o(busy[1])
    );
    stdout_hex_tx #(.CLK_DIV(868)) u_div868 (
        .clk_i(clk), .rst_n(rst_n), .stdout_val_i(val[2]), .stdout_data_i(data[2]),
        .stdout_rdy_o(rdy[2]), .tx_o(tx[2]), .busy_o(busy[2])
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    int burst_start [3] = '{0, 0, 0};
    int last_end    [3] = '{-1, -1, -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int exp_size(input int i);
        case (i)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void push_exp(input int i, input logic [7:0] b);
        case (i)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] pop_exp(input int i);
        case (i)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    // Reference: word printed as 4 uppercase hex digits then CR LF.
    function automatic logic [7:0] nib_char(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    function automatic void push_word(input int i, input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
            push_exp(i, nib_char((int'(w) >> (12 - 4 * k)) & 15));
        end
        push_exp(i, 8'h0D);
        push_exp(i, 8'h0A);
    endfunction

    // UART decoder: checks each bit is a constant run of exactly d cycles, then scores the byte.
    task automatic monitor(input int i, input int d);
        logic [9:0]  bits;
        logic [7:0]  want;
        bit          ok;
        bit          aborted;
        int          st;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx[i] === 1'b0) begin
                st      = cyc;
                ok      = 1'b1;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < d; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                        if (s == 0) bits[b] = tx[i];
                        else if (tx[i] !== bits[b]) ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (st != last_end[i]) burst_start[i] = st;
                    last_end[i] = st + 10 * d;
                    check($sformatf("frame_u%0d", i), 32'({ok, bits[0], bits[9]}), 32'b101);
                    if (exp_size(i) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_char_u%0d: got %0h, required none", i,
                                 bits[8:1]);
                    end else begin
                        want = pop_exp(i);
                        check($sformatf("char_u%0d", i), 32'(bits[8:1]), 32'(want));
                    end
                end
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 2);
    initial monitor(2, 868);

    // Called at a negedge; leaves val high and returns at the negedge after the accept edge.
    task automatic send(input int i, input logic [15:0] w, input int budget, output int acc);
        int n = 0;
        val[i] = 1'b1;
        while (rdy[i] !== 1'b1 && n < budget) begin
            data[i] = 16'($urandom);
            @(negedge clk);
            n++;
        end
        data[i] = w;
        if (rdy[i] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_wait_u%0d: got no ready in %0d cycles, required ready", i, n);
            val[i] = 1'b0;
            acc    = -1;
            return;
        end
        acc = cyc + 1;
        push_word(i, w);
        @(negedge clk);
    endtask

    task automatic drain(input int i, input int budget);
        int n = 0;
        while ((exp_size(i) != 0 || busy[i] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain_pending_u%0d", i), 32'(exp_size(i)), 32'd0);
        check($sformatf("drain_busy_u%0d", i), 32'(busy[i]), 32'd0);
    endtask

    int a1, a2, a3, bad;
    logic [15:0] w;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            val[i]  = 1'b0;
            data[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx[0]), 32'd1);
        check("reset_rdy", 32'(rdy[0]), 32'd0);
        check("reset_busy", 32'(busy[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_reset", 32'(rdy[0]), 32'd1);
        @(negedge clk);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
        end
        check("idle_100", 32'(bad), 32'd0);

        // Single word: latency and total length.
        send(0, 16'h1A2F, 10, a1);
        val[0] = 1'b0;
        drain(0, 1000);
        check("latency_1a2f", 32'(burst_start[0]), 32'(a1 + 1));
        check("span_1a2f", 32'(last_end[0] - burst_start[0]), 32'd240);

        // Back-to-back words with val held high.
        repeat (20) @(negedge clk);
        send(0, 16'h0000, 10, a1);
        send(0, 16'hFFFF, 10, a2);
        send(0, 16'h8001, 1000, a3);
        val[0] = 1'b0;
        drain(0, 2000);
        check("accept2_next_cycle", 32'(a2), 32'(a1 + 1));
        check("accept3_at_handoff", 32'(a3), 32'(a1 + 242));
        check("latency_b2b", 32'(burst_start[0]), 32'(a1 + 1));
        check("span_b2b", 32'(last_end[0] - burst_start[0]), 32'd720);

        // Reset during data bit 3 of 'E' (0x45, bit 3 = 0).
        repeat (20) @(negedge clk);
        send(0, 16'hBEEF, 10, a1);
        val[0] = 1'b0;
        while (cyc < a1 + 58) @(negedge clk);
        check("bit3_before_reset", 32'(tx[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx[0]), 32'd1);
        check("abort_rdy", 32'(rdy[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        exp_q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        send(0, 16'h0007, 10, a1);
        val[0] = 1'b0;
        drain(0, 1000);
        check("latency_0007", 32'(burst_start[0]), 32'(a1 + 1));
        check("span_0007", 32'(last_end[0] - burst_start[0]), 32'd240);

        // Random words, mixing back-to-back streams and idle gaps.
        repeat (10) @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            w = 16'($urandom);
            send(0, w, 2000, a1);
            if ($urandom_range(0, 1) == 1) begin
                val[0] = 1'b0;
                repeat ($urandom_range(0, 300)) @(negedge clk);
            end
        end
        val[0] = 1'b0;
        drain(0, 20000);

        // Other dividers.
        send(1, 16'hC0DE, 10, a1);
        val[1] = 1'b0;
        send(2, 16'hC0DE, 10, a2);
        val[2] = 1'b0;
        drain(1, 2000);
        check("latency_div2", 32'(burst_start[1]), 32'(a1 + 1));
        check("span_div2", 32'(last_end[1] - burst_start[1]), 32'd120);
        drain(2, 60000);
        check("latency_div868", 32'(burst_start[2]), 32'(a2 + 1));
        check("span_div868", 32'(last_end[2] - burst_start[2]), 32'd52080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stdout_hex_tx.md
STDOUT_HEX_TX -- requirements
Module: stdout_hex_tx

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk_i  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stdout_val_i  input  1  producer has a word on stdout_data_i.
REQ-005 stdout_data_i  input  16  word to print.
REQ-006 stdout_rdy_o  output  1  block can accept a word this cycle.
REQ-007 tx_o  output  1  UART serial line, idle high.
REQ-008 busy_o  output  1  a character frame is on tx_o or a word is pending.

Function
REQ-009 Handshake: a word SHALL transfer on any rising edge where stdout_val_i && stdout_rdy_o; data is sampled only on that edge.
REQ-010 Buffering: a one-entry holding register; stdout_rdy_o SHALL equal ~holding_full, combinationally independent of stdout_val_i.
REQ-011 Word format: 6 characters in order: hex nibbles [15:12], [11:8], [7:4], [3:0], then 0x0D, then 0x0A.
REQ-012 Nibble encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
REQ-013 Character frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLK_DIV cycles; 10*CLK_DIV cycles per character; no gap between the 6 characters of a word.
REQ-014 Serializer states: IDLE, START, DATA, STOP; IDLE->START when a character is available; START->DATA after CLK_DIV cycles; DATA->STOP after 8th bit's CLK_DIV cycles; STOP->START if another character is available at the end of the stop bit, else STOP->IDLE.
REQ-015 Latency: word accepted at edge N while IDLE with empty holding register -> tx_o low from edge N+1.
REQ-016 Holding register is moved to the active word register when the previous word's LF stop bit completes; the next start bit SHALL follow immediately (no idle cycles between back-to-back words).
REQ-017 Simultaneous accept and hand-off in the same cycle: holding register is loaded with the new word and the old contents move to the active register; no word lost or duplicated.
REQ-018 Baud counter SHALL count CLK_DIV-1 down to 0; width $clog2(CLK_DIV); bit index 0..7; character index 0..5, wraps to 0 after LF.
REQ-019 busy_o SHALL be 1 from the edge after accept until the last stop bit of the last pending word completes.
REQ-020 tx_o SHALL be registered (glitch-free); stdout_data_i changes while not accepted have no effect.

Reset
REQ-021 While rst_n=0: tx_o=1, stdout_rdy_o=0, busy_o=0, state IDLE, all counters 0, holding register empty.
REQ-022 First edge after rst_n rises: stdout_rdy_o=1.
REQ-023 Reset mid-frame aborts the frame; tx_o returns high asynchronously; buffered words are discarded.

Structure
REQ-024 Shared package toy_pkg holds: ASCII_CR=8'h0D, ASCII_LF=8'h0A, HEX_CHARS_PER_WORD=4, and function hex_ascii(4-bit) -> 8-bit.
REQ-025 One sub-module uart_tx_byte (8-bit val/rdy input, CLK_DIV parameter, tx_o output) SHALL implement REQ-013/014; stdout_hex_tx holds buffering and character sequencing.

Verification (CLK_DIV=4 unless stated)
REQ-026 Reset, then idle 100 cycles -> tx_o=1 throughout, busy_o=0, stdout_rdy_o=1.
REQ-027 Send 16'h1A2F -> tx_o decodes to bytes 0x31,0x41,0x32,0x46,0x0D,0x0A; exactly 240 cycles from first falling edge to end of LF stop bit; tx_o low at edge N+1.
REQ-028 Hold stdout_val_i=1 with words 16'h0000, 16'hFFFF, 16'h8001 -> second accept occurs next cycle, third accept waits for hand-off; output "0000\r\nFFFF\r\n8001\r\n" with no idle bits between words (720 cycles).
REQ-029 Accept presented in the exact cycle the holding register hands off -> no loss, no duplicate, order preserved.
REQ-030 Assert rst_n=0 during bit 3 of the second character of 16'hBEEF -> tx_o=1 immediately, stdout_rdy_o=0; after release, send 16'h0007 -> clean "0007\r\n".
REQ-031 CLK_DIV=2 and CLK_DIV=868 with 16'hC0DE -> each bit width exactly CLK_DIV cycles, decoded "C0DE\r\n".
